echo_delay: RTL and testbench

ECHO_DELAY -- requirements
Module: echo_delay

---
 rtl/echo_delay_pkg.sv | 25 ++
 rtl/echo_sat_mac.sv | 38 +++
 rtl/echo_delay.sv | 163 ++++++++++++++++
 tb/tb_echo_delay.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_delay_pkg.sv
// Shared definitions for the echo/delay block: FSM state encoding,
// Q0.8 gain format and signed saturation limits.
package echo_delay_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam int GAIN_W  = 8;
    localparam int Q_SHIFT = 8;

    // Largest / smallest value representable in a w-bit two's-complement sample.
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/echo_sat_mac.sv
// Combinational y = sat(a + ((b * g) >>> 8)) with g an unsigned Q0.8 gain;
// the shift is arithmetic, so negative products round toward minus infinity.
module echo_sat_mac
    import echo_delay_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic        [GAIN_W-1:0] g_i,
    output logic signed [DATA_W-1:0] y_o
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(DATA_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(DATA_W));

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] scaled;
    logic signed [ACC_W-1:0]  acc;

    // Gain is zero-extended so it stays non-negative in the signed multiply.
    assign prod   = PROD_W'(b_i) * PROD_W'($signed({1'b0, g_i}));
    assign scaled = prod >>> Q_SHIFT;
    assign acc    = ACC_W'(a_i) + ACC_W'(scaled);

    always_comb begin
        if (acc > ACC_MAX) begin
            y_o = ACC_MAX[DATA_W-1:0];
        end else if (acc < ACC_MIN) begin
            y_o = ACC_MIN[DATA_W-1:0];
        end else begin
            y_o = acc[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/echo_delay.sv
// Echo/delay effect over an external asynchronous SRAM used as a circular delay line.
// Define ECHO_FEEDBACK_EN to write back dry + scaled delayed sample (decaying repeats).
module echo_delay
    import echo_delay_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 20000
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] input_frame,
    input  logic        [ADDR_W-1:0] delay_len,
    input  logic        [GAIN_W-1:0] mix,
    input  logic        [GAIN_W-1:0] feedback,
    output logic signed [DATA_W-1:0] output_frame,
    output logic                     output_valid,
    output logic                     overrun,
    output logic        [ADDR_W-1:0] SRAM_ADDR,
    inout  wire         [DATA_W-1:0] SRAM_DQ,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_OE_N
);

    // One extra bit so a length of exactly 2**ADDR_W is representable.
    localparam int LEN_W = ADDR_W + 1;

    state_e                    state_q, state_d;
    logic signed [DATA_W-1:0]  dry_q;
    logic signed [DATA_W-1:0]  dly_q;
    logic signed [DATA_W-1:0]  out_q;
    logic signed [DATA_W-1:0]  wdata_q;
    logic        [LEN_W-1:0]   len_q;
    logic        [ADDR_W-1:0]  ptr_q;
    logic        [ADDR_W-1:0]  addr_q;
    logic                      primed_q;
    logic                      out_valid_q;
    logic                      overrun_q;
    logic                      we_n_q;
    logic                      oe_n_q;

    logic        [LEN_W-1:0]   len_req;
    logic        [LEN_W-1:0]   len_clamped;
    logic        [LEN_W-1:0]   ptr_inc;
    logic                      ptr_wrap;
    logic signed [DATA_W-1:0]  wet_sum;
    logic signed [DATA_W-1:0]  wr_val;

    assign len_req = {1'b0, delay_len};

    always_comb begin
        if (len_req == '0) begin
            len_clamped = LEN_W'(1);
        end else if (len_req > LEN_W'(DEPTH)) begin
            len_clamped = LEN_W'(DEPTH);
        end else begin
            len_clamped = len_req;
        end
    end

    // A length shrink below the current pointer also lands here and wraps to 0.
    assign ptr_inc  = {1'b0, ptr_q} + LEN_W'(1);
    assign ptr_wrap = (ptr_inc >= len_q);

    echo_sat_mac #(.DATA_W(DATA_W)) u_out_mac (
        .a_i (dry_q),
        .b_i (dly_q),
        .g_i (mix),
        .y_o (wet_sum)
    );

`ifdef ECHO_FEEDBACK_EN
    echo_sat_mac #(.DATA_W(DATA_W)) u_fb_mac (
        .a_i (dry_q),
        .b_i (dly_q),
        .g_i (feedback),
        .y_o (wr_val)
    );
`else
    logic unused_feedback;
    assign unused_feedback = ^feedback;
    assign wr_val          = dry_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (sample_valid) state_d = ST_READ;
            ST_READ:    state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_WRITE;
            ST_WRITE:   state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            dry_q       <= '0;
            dly_q       <= '0;
            out_q       <= '0;
            wdata_q     <= '0;
            len_q       <= LEN_W'(1);
            ptr_q       <= '0;
            addr_q      <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            if (sample_valid && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sample_valid) begin
                        dry_q  <= input_frame;
                        len_q  <= len_clamped;
                        addr_q <= ptr_q;
                        oe_n_q <= 1'b0;
                    end
                end
                ST_READ: begin
                    // Data settled during the read cycle; stale RAM is masked until the first wrap.
                    dly_q  <= primed_q ? $signed(SRAM_DQ) : '0;
                    oe_n_q <= 1'b1;
                end
                ST_CAPTURE: begin
                    addr_q  <= ptr_q;
                    wdata_q <= wr_val;
                    we_n_q  <= 1'b0;
                end
                ST_WRITE: begin
                    we_n_q      <= 1'b1;
                    out_q       <= wet_sum;
                    out_valid_q <= 1'b1;
                end
                ST_DONE: begin
                    ptr_q <= ptr_wrap ? '0 : ptr_inc[ADDR_W-1:0];
                    if (ptr_wrap) begin
                        primed_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The data driver is keyed to the write strobe itself, so it can never fight a read.
    assign SRAM_DQ      = we_n_q ? {DATA_W{1'bz}} : wdata_q;
    assign SRAM_ADDR    = addr_q;
    assign SRAM_WE_N    = we_n_q;
    assign SRAM_OE_N    = oe_n_q;
    assign output_frame = out_q;
    assign output_valid = out_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_echo_delay.sv
// Self-checking bench for echo_delay with a behavioural SRAM and a delay-line reference model.
module tb_echo_delay;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 40;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sample_valid;
    logic signed [DW-1:0] input_frame;
    logic        [AW-1:0] delay_len;
    logic        [7:0]    mix;
    logic        [7:0]    feedback;
    logic signed [DW-1:0] output_frame;
    logic                 output_valid;
    logic                 overrun;
    logic        [AW-1:0] sram_addr;
    wire         [DW-1:0] sram_dq;
    logic                 sram_we_n;
    logic                 sram_oe_n;

    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic          preload_en;
    logic [AW-1:0] preload_addr;
    logic [DW-1:0] preload_data;

    int n_cmp, n_bad;
    int m_mem [0:(1<<AW)-1];
    int m_ptr;
    bit m_primed;
    int exp_out, exp_addr, exp_w;
    int obs_lat, obs_nvalid, obs_out, obs_wr_cnt, obs_wr_addr, obs_wr_data, obs_both;

    always #5 clk = ~clk;

    echo_delay #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .CLK          (clk),
        .RESET        (rst),
        .sample_valid (sample_valid),
        .input_frame  (input_frame),
        .delay_len    (delay_len),
        .mix          (mix),
        .feedback     (feedback),
        .output_frame (output_frame),
        .output_valid (output_valid),
        .overrun      (overrun),
        .SRAM_ADDR    (sram_addr),
        .SRAM_DQ      (sram_dq),
        .SRAM_WE_N    (sram_we_n),
        .SRAM_OE_N    (sram_oe_n)
    );

    // Asynchronous-read SRAM; writes land on the clock edge that ends a WE_N-low cycle.
    assign sram_dq = (!sram_oe_n && sram_we_n) ? sram[sram_addr] : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_we_n) sram[sram_addr] <= sram_dq;
        else if (preload_en) sram[preload_addr] <= preload_data;
    end

    function automatic int floor256(input int p);
        int q;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: circular delay line of length L, delayed sample reads as 0 until the first wrap.
    task automatic model_step(input int dry, input int dl, input int mx, input int fb);
        int len, d;
        len = (dl < 1) ? 1 : ((dl > DEPTH) ? DEPTH : dl);
        d = m_primed ? m_mem[m_ptr] : 0;
        exp_out = sat16(dry + floor256(d * mx));
`ifdef ECHO_FEEDBACK_EN
        exp_w = sat16(dry + floor256(d * fb));
`else
        exp_w = dry + 0 * fb;
`endif
        exp_addr = m_ptr;
        m_mem[m_ptr] = exp_w;
        m_ptr = m_ptr + 1;
        if (m_ptr >= len) begin
            m_ptr = 0;
            m_primed = 1'b1;
        end
    endtask

    task automatic clear_obs;
        obs_lat = 0; obs_nvalid = 0; obs_out = 0; obs_wr_cnt = 0;
        obs_wr_addr = -1; obs_wr_data = 0; obs_both = 0;
    endtask

    task automatic observe(input int k);
        logic signed [DW-1:0] dq_s;
        if (output_valid) begin
            obs_nvalid++;
            if (obs_lat == 0) obs_lat = k;
            obs_out = int'(output_frame);
        end
        if (!sram_we_n) begin
            obs_wr_cnt++;
            obs_wr_addr = int'(sram_addr);
            dq_s = sram_dq;
            obs_wr_data = int'(dq_s);
        end
        if (!sram_we_n && !sram_oe_n) obs_both++;
    endtask

    task automatic drive(input int dry, input int dl, input int mx, input int fb);
        @(negedge clk);
        sample_valid = 1'b1;
        input_frame  = 16'(dry);
        delay_len    = 6'(dl);
        mix          = 8'(mx);
        feedback     = 8'(fb);
    endtask

    // One accepted sample: k counts rising edges starting with the accepting edge.
    task automatic send(input int dry, input int dl, input int mx, input int fb);
        model_step(dry, dl, mx, fb);
        clear_obs;
        drive(dry, dl, mx, fb);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            sample_valid = 1'b0;
            observe(k);
        end
        $display("txn dry=%0d len=%0d mix=%0d fb=%0d -> out=%0d lat=%0d waddr=%0d wdata=%0d",
                 dry, dl, mx, fb, obs_out, obs_lat, obs_wr_addr, obs_wr_data);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        m_primed = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if (output_frame !== 16'sd0) begin n_bad++; $display("FAIL reset_out: got %0d want 0", output_frame); end
        n_cmp++; if (output_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", output_valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
        n_cmp++; if (sram_oe_n !== 1'b1) begin n_bad++; $display("FAIL reset_oe_n: got %b want 1", sram_oe_n); end
        n_cmp++; if (sram_addr !== 6'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", sram_addr); end
    endtask

    task automatic test_impulse;
        int want [12] = '{1000, 0, 0, 0, 500, 0, 0, 0, 0, 0, 0, 0};
        do_reset;
        for (int i = 0; i < 12; i++) begin
            send((i == 0) ? 1000 : 0, 4, 128, 0);
            n_cmp++; if (obs_out !== want[i]) begin n_bad++; $display("FAIL impulse_out[%0d]: got %0d want %0d", i, obs_out, want[i]); end
            n_cmp++; if (obs_lat !== 4) begin n_bad++; $display("FAIL impulse_lat[%0d]: got %0d want 4", i, obs_lat); end
        end
    endtask

    task automatic test_saturation;
        int dry  [4] = '{32000, 32000, -32000, -32000};
        int want [4] = '{32000, 32767, -125, -32768};
        do_reset;
        for (int i = 0; i < 4; i++) begin
            send(dry[i], 1, 255, 0);
            n_cmp++; if (obs_out !== want[i]) begin n_bad++; $display("FAIL sat_out[%0d]: got %0d want %0d", i, obs_out, want[i]); end
        end
    endtask

    task automatic test_shrink;
        do_reset;
        for (int i = 0; i < 6; i++) send($urandom_range(0, 2000) - 1000, 8, 50, 0);
        send(300, 3, 50, 0);
        n_cmp++; if (obs_wr_addr !== 6) begin n_bad++; $display("FAIL shrink_addr_before: got %0d want 6", obs_wr_addr); end
        send(200, 0, 128, 0);
        n_cmp++; if (obs_wr_addr !== 0) begin n_bad++; $display("FAIL shrink_wrap_addr: got %0d want 0", obs_wr_addr); end
        n_cmp++; if (obs_out !== exp_out) begin n_bad++; $display("FAIL shrink_out: got %0d want %0d", obs_out, exp_out); end
        send(0, 0, 128, 0);
        n_cmp++; if (obs_wr_addr !== 0) begin n_bad++; $display("FAIL len0_addr: got %0d want 0", obs_wr_addr); end
        n_cmp++; if (obs_out !== 100) begin n_bad++; $display("FAIL len0_out: got %0d want 100", obs_out); end
    endtask

    task automatic test_overrun;
        do_reset;
        model_step(1234, 2, 64, 0);
        clear_obs;
        drive(1234, 2, 64, 0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 2) sample_valid = 1'b0;
            observe(k);
        end
        n_cmp++; if (obs_nvalid !== 1) begin n_bad++; $display("FAIL ovr_nvalid: got %0d want 1", obs_nvalid); end
        n_cmp++; if (obs_lat !== 4) begin n_bad++; $display("FAIL ovr_lat: got %0d want 4", obs_lat); end
        n_cmp++; if (obs_out !== exp_out) begin n_bad++; $display("FAIL ovr_out: got %0d want %0d", obs_out, exp_out); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        for (int i = 0; i < 3; i++) send(100 * i, 2, 64, 0);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        do_reset;
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_done_drop;
        logic ov_before;
        ov_before = 1'b1;
        do_reset;
        model_step(-555, 3, 90, 0);
        clear_obs;
        drive(-555, 3, 90, 0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 1) sample_valid = 1'b0;
            if (k == 4) begin ov_before = overrun; sample_valid = 1'b1; end
            if (k == 5) sample_valid = 1'b0;
            observe(k);
        end
        n_cmp++; if (ov_before !== 1'b0) begin n_bad++; $display("FAIL done_ov_before: got %b want 0", ov_before); end
        n_cmp++; if (obs_nvalid !== 1) begin n_bad++; $display("FAIL done_nvalid: got %0d want 1", obs_nvalid); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL done_overrun: got %b want 1", overrun); end
        n_cmp++; if (obs_out !== exp_out) begin n_bad++; $display("FAIL done_out: got %0d want %0d", obs_out, exp_out); end
    endtask

    task automatic test_reset_mid;
        int dry;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            send($urandom_range(0, 20000) - 10000, 4, 100, 30);
            n_cmp++; if (obs_out !== exp_out) begin n_bad++; $display("FAIL pre_abort_out[%0d]: got %0d want %0d", i, obs_out, exp_out); end
        end
        model_step(777, 4, 100, 30);
        drive(777, 4, 100, 30);
        @(posedge clk); #1; sample_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (sram_we_n !== 1'b0) begin n_bad++; $display("FAIL abort_in_write: got we_n=%b want 0", sram_we_n); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL abort_we_n: got %b want 1", sram_we_n); end
        n_cmp++; if (sram_oe_n !== 1'b1) begin n_bad++; $display("FAIL abort_oe_n: got %b want 1", sram_oe_n); end
        n_cmp++; if (output_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", output_valid); end
        rst = 1'b0;
        m_ptr = 0;
        m_primed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dry = $urandom_range(0, 20000) - 10000;
            send(dry, 4, 200, 0);
            if (i < 4) begin
                n_cmp++; if (obs_out !== dry) begin n_bad++; $display("FAIL post_abort_dry[%0d]: got %0d want %0d", i, obs_out, dry); end
            end else begin
                n_cmp++; if (obs_out !== exp_out) begin n_bad++; $display("FAIL post_abort_echo: got %0d want %0d", obs_out, exp_out); end
            end
            n_cmp++; if (obs_lat !== 4) begin n_bad++; $display("FAIL post_abort_lat[%0d]: got %0d want 4", i, obs_lat); end
        end
    endtask

    task automatic test_random;
        int dl, use_dl, sel;
        do_reset;
        dl = 3;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) dl = $urandom_range(1, 7);
            else if (sel == 1) dl = 0;
            use_dl = (sel == 2) ? 63 : dl;
            send($urandom_range(0, 65535) - 32768, use_dl, $urandom_range(0, 255), $urandom_range(0, 255));
            n_cmp++; if (obs_out !== exp_out) begin n_bad++; $display("FAIL rand_out[%0d]: got %0d want %0d", i, obs_out, exp_out); end
            n_cmp++; if (obs_lat !== 4) begin n_bad++; $display("FAIL rand_lat[%0d]: got %0d want 4", i, obs_lat); end
            n_cmp++; if (obs_wr_cnt !== 1) begin n_bad++; $display("FAIL rand_wr_cnt[%0d]: got %0d want 1", i, obs_wr_cnt); end
            n_cmp++; if (obs_wr_addr !== exp_addr) begin n_bad++; $display("FAIL rand_wr_addr[%0d]: got %0d want %0d", i, obs_wr_addr, exp_addr); end
            n_cmp++; if (obs_wr_data !== exp_w) begin n_bad++; $display("FAIL rand_wr_data[%0d]: got %0d want %0d", i, obs_wr_data, exp_w); end
            n_cmp++; if (obs_both !== 0) begin n_bad++; $display("FAIL rand_we_oe_both_low[%0d]: got %0d want 0", i, obs_both); end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; sample_valid = 1'b0; input_frame = '0; delay_len = '0;
        mix = '0; feedback = '0;
        preload_en = 1'b0; preload_addr = '0; preload_data = '0;
        m_ptr = 0; m_primed = 1'b0;
        exp_out = 0; exp_addr = 0; exp_w = 0;
        clear_obs;
        // Fill the SRAM with garbage while reset is held; the model keeps its own copy.
        for (int i = 0; i < (1 << AW); i++) begin
            @(negedge clk);
            preload_en   = 1'b1;
            preload_addr = 6'(i);
            preload_data = 16'($urandom);
            m_mem[i]     = int'($signed(preload_data));
        end
        @(negedge clk);
        preload_en = 1'b0;

        test_reset;
        test_impulse;
        test_saturation;
        test_shrink;
        test_overrun;
        test_done_drop;
        test_reset_mid;
        test_random;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
